// File: rtl/commit_trace_monitor.sv
// ----------------------------------------------------------------------------
// commit_trace_monitor
//
// Retirement monitor that sits beside the datapath and watches the commit
// signals of up to NRET lanes per cycle (lane 0 oldest in program order).
// It numbers every accepted commit with a 64-bit order, detects a halt
// (a commit whose next PC equals its own PC) and a commit timeout (TIMEOUT
// consecutive commit-free cycles). The most recent DEPTH commits are kept in a
// ring and can be drained through a show-ahead read port for debug.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   commit_valid    per-lane retire strobe
//   commit_pc       per-lane PC            (lane i at [32*i +: 32])
//   commit_pc_next  per-lane next PC
//   commit_load     per-lane regfile write enable
//   commit_rd       per-lane destination register (lane i at [5*i +: 5])
//   commit_wdata    per-lane regfile write data
//   rd_en           pop head entry (ignored while rd_valid is low)
//   rd_valid        ring holds at least one entry
//   rd_pc/rd_rd/rd_wdata/rd_order  head entry fields, zero when empty
//   count           entries held
//   order           total accepted commits
//   halt            branch-to-self retired (sticky)
//   timeout         TIMEOUT commit-free cycles elapsed (sticky)
//   overflow        an unread entry was overwritten (sticky)
// ----------------------------------------------------------------------------
module commit_trace_monitor #(
    parameter int NRET    = 1,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 100000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRET-1:0]            commit_valid,
    input  logic [NRET*32-1:0]         commit_pc,
    input  logic [NRET*32-1:0]         commit_pc_next,
    input  logic [NRET-1:0]            commit_load,
    input  logic [NRET*5-1:0]          commit_rd,
    input  logic [NRET*32-1:0]         commit_wdata,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [31:0]                rd_pc,
    output logic [4:0]                 rd_rd,
    output logic [31:0]                rd_wdata,
    output logic [63:0]                rd_order,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [63:0]                order,
    output logic                       halt,
    output logic                       timeout,
    output logic                       overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;          // holds count + NRET pushes
    localparam int ACC_W  = $clog2(NRET + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_TIMED_OUT
    } state_e;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pc;
    } entry_t;

    // State registers
    state_e              state_q, state_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [63:0]         order_q, order_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    entry_t              mem_q [DEPTH];

    // Per-lane write requests into the ring
    logic                wr_en    [NRET];
    logic [PTR_W-1:0]    wr_idx   [NRET];
    entry_t              wr_entry [NRET];

    logic                pop;
    logic [ACC_W-1:0]    n_acc;
    logic                stop;
    logic [4:0]          lane_rd;
    logic [PTR_W-1:0]    head_pop;
    logic [SUM_W-1:0]    cnt_pop;
    logic [SUM_W-1:0]    cnt_push;

    entry_t              head_entry;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        idle_d     = idle_q;
        overflow_d = overflow_q;
        n_acc      = '0;
        stop       = 1'b0;
        lane_rd    = '0;

        // NOTE: blocking assignments here on purpose: n_acc/stop accumulate lane by lane in order.
        for (int i = 0; i < NRET; i++) begin
            wr_en[i]    = 1'b0;
            wr_idx[i]   = '0;
            wr_entry[i] = '0;
            if (state_q == ST_RUN && !stop && commit_valid[i]) begin
                lane_rd            = commit_load[i] ? commit_rd[5*i +: 5] : 5'd0;
                wr_en[i]           = 1'b1;
                wr_idx[i]          = tail_q + PTR_W'(n_acc);
                wr_entry[i].pc     = commit_pc[32*i +: 32];
                wr_entry[i].rd     = lane_rd;
                wr_entry[i].wdata  = (lane_rd == 5'd0) ? 32'd0 : commit_wdata[32*i +: 32];
                wr_entry[i].order  = order_q + 64'(n_acc);
                n_acc              = n_acc + 1'b1;
                // A self-loop retires but closes acceptance for younger lanes.
                if (commit_pc_next[32*i +: 32] == commit_pc[32*i +: 32]) begin
                    stop = 1'b1;
                end
            end
        end

        order_d = order_q + 64'(n_acc);

        if (state_q == ST_RUN) begin
            if (stop) begin
                state_d = ST_HALTED;
            end
            if (n_acc != '0) begin
                idle_d = '0;
            end else begin
                if (idle_q < IDLE_W'(TIMEOUT)) begin
                    idle_d = idle_q + 1'b1;
                end
                if (idle_d == IDLE_W'(TIMEOUT)) begin
                    state_d = ST_TIMED_OUT;
                end
            end
        end

        // Ring: pop first, then push; anything beyond DEPTH evicts the oldest.
        pop      = rd_en && rd_valid;
        head_pop = head_q + PTR_W'(pop);
        cnt_pop  = SUM_W'(count_q) - SUM_W'(pop);
        cnt_push = cnt_pop + SUM_W'(n_acc);
        tail_d   = tail_q + PTR_W'(n_acc);
        if (cnt_push > SUM_W'(DEPTH)) begin
            head_d     = head_pop + PTR_W'(cnt_push - SUM_W'(DEPTH));
            count_d    = CNT_W'(DEPTH);
            overflow_d = 1'b1;
        end else begin
            head_d     = head_pop;
            count_d    = CNT_W'(cnt_push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            idle_q     <= '0;
            order_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            order_q    <= order_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: ring storage is deliberately not reset; count_q gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= wr_entry[i];
            end
        end
    end

    assign head_entry = mem_q[head_q];

    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_valid ? head_entry.pc    : 32'd0;
    assign rd_rd    = rd_valid ? head_entry.rd    : 5'd0;
    assign rd_wdata = rd_valid ? head_entry.wdata : 32'd0;
    assign rd_order = rd_valid ? head_entry.order : 64'd0;

    assign count    = count_q;
    assign order    = order_q;
    assign halt     = (state_q == ST_HALTED);
    assign timeout  = (state_q == ST_TIMED_OUT);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_commit_trace_monitor
//
// Directed bench for commit_trace_monitor configured with two commit lanes, a
// four-entry ring and a five-cycle timeout. Inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_commit_trace_monitor;

    localparam int NRET    = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRET-1:0]      commit_valid;
    logic [NRET*32-1:0]   commit_pc;
    logic [NRET*32-1:0]   commit_pc_next;
    logic [NRET-1:0]      commit_load;
    logic [NRET*5-1:0]    commit_rd;
    logic [NRET*32-1:0]   commit_wdata;
    logic                 rd_en;
    logic                 rd_valid;
    logic [31:0]          rd_pc;
    logic [4:0]           rd_rd;
    logic [31:0]          rd_wdata;
    logic [63:0]          rd_order;
    logic [2:0]           count;
    logic [63:0]          order;
    logic                 halt;
    logic                 timeout;
    logic                 overflow;

    int n_tests = 0;
    int n_fail  = 0;

    commit_trace_monitor #(
        .NRET    (NRET),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_pc_next (commit_pc_next),
        .commit_load    (commit_load),
        .commit_rd      (commit_rd),
        .commit_wdata   (commit_wdata),
        .rd_en          (rd_en),
        .rd_valid       (rd_valid),
        .rd_pc          (rd_pc),
        .rd_rd          (rd_rd),
        .rd_wdata       (rd_wdata),
        .rd_order       (rd_order),
        .count          (count),
        .order          (order),
        .halt           (halt),
        .timeout        (timeout),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        commit_valid   = '0;
        commit_pc      = '0;
        commit_pc_next = '0;
        commit_load    = '0;
        commit_rd      = '0;
        commit_wdata   = '0;
        rd_en          = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] pc_next,
                            input logic load, input logic [4:0] rd, input logic [31:0] wdata);
        commit_valid[l]          = 1'b1;
        commit_pc[32*l +: 32]      = pc;
        commit_pc_next[32*l +: 32] = pc_next;
        commit_load[l]           = load;
        commit_rd[5*l +: 5]      = rd;
        commit_wdata[32*l +: 32] = wdata;
    endtask

    // One ordinary lane-0 commit with a regfile write.
    task automatic commit1(input logic [31:0] pc);
        clear_inputs();
        set_lane(0, pc, pc + 32'd4, 1'b1, 5'd1, pc + 32'h1000);
        tick();
        clear_inputs();
    endtask

    task automatic pop1();
        clear_inputs();
        rd_en = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        commit1(32'h40);
        commit1(32'h44);
        do_reset();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (order !== 64'd0) begin n_fail++; $display("FAIL reset_order: got %0d expected 0", order); end
        n_tests++; if ({halt, timeout, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {halt, timeout, overflow}); end
        n_tests++; if (rd_pc !== 32'd0 || rd_order !== 64'd0) begin n_fail++; $display("FAIL reset_rd_fields: got pc %h order %0d expected 0/0", rd_pc, rd_order); end
    endtask

    task automatic test_single_lane();
        do_reset();
        clear_inputs();
        set_lane(0, 32'h60, 32'h64, 1'b1, 5'd5, 32'hAA);
        tick();
        clear_inputs();
        set_lane(0, 32'h64, 32'h68, 1'b1, 5'd0, 32'h55);
        tick();
        clear_inputs();
        n_tests++; if (order !== 64'd2) begin n_fail++; $display("FAIL single_order: got %0d expected 2", order); end
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL single_count: got %0d expected 2", count); end
        n_tests++; if (rd_pc !== 32'h60 || rd_rd !== 5'd5 || rd_wdata !== 32'hAA || rd_order !== 64'd0)
            begin n_fail++; $display("FAIL single_head0: got %h/%0d/%h/%0d expected 60/5/aa/0", rd_pc, rd_rd, rd_wdata, rd_order); end
        pop1();
        n_tests++; if (rd_pc !== 32'h64 || rd_rd !== 5'd0 || rd_wdata !== 32'd0 || rd_order !== 64'd1)
            begin n_fail++; $display("FAIL single_head1: got %h/%0d/%h/%0d expected 64/0/0/1", rd_pc, rd_rd, rd_wdata, rd_order); end
        pop1();
        n_tests++; if (rd_valid !== 1'b0 || count !== 3'd0 || rd_pc !== 32'd0)
            begin n_fail++; $display("FAIL single_empty: got valid %0b count %0d pc %h expected 0/0/0", rd_valid, count, rd_pc); end
    endtask

    task automatic test_dual_lane();
        do_reset();
        clear_inputs();
        set_lane(0, 32'h10, 32'h14, 1'b0, 5'd7, 32'h33);
        set_lane(1, 32'h14, 32'h18, 1'b1, 5'd3, 32'h44);
        tick();
        clear_inputs();
        n_tests++; if (order !== 64'd2 || count !== 3'd2) begin n_fail++; $display("FAIL dual_order_count: got %0d/%0d expected 2/2", order, count); end
        n_tests++; if (rd_pc !== 32'h10 || rd_rd !== 5'd0 || rd_wdata !== 32'd0 || rd_order !== 64'd0)
            begin n_fail++; $display("FAIL dual_lane0: got %h/%0d/%h/%0d expected 10/0/0/0", rd_pc, rd_rd, rd_wdata, rd_order); end
        pop1();
        n_tests++; if (rd_pc !== 32'h14 || rd_rd !== 5'd3 || rd_wdata !== 32'h44 || rd_order !== 64'd1)
            begin n_fail++; $display("FAIL dual_lane1: got %h/%0d/%h/%0d expected 14/3/44/1", rd_pc, rd_rd, rd_wdata, rd_order); end
    endtask

    task automatic test_halt();
        do_reset();
        clear_inputs();
        set_lane(0, 32'h80, 32'h80, 1'b0, 5'd0, 32'd0);
        set_lane(1, 32'h84, 32'h88, 1'b1, 5'd2, 32'h12);
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %0b expected 0", halt); end
        tick();
        clear_inputs();
        n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %0b expected 1", halt); end
        n_tests++; if (order !== 64'd1 || count !== 3'd1) begin n_fail++; $display("FAIL halt_lane1_dropped: got order %0d count %0d expected 1/1", order, count); end
        n_tests++; if (rd_pc !== 32'h80 || rd_order !== 64'd0) begin n_fail++; $display("FAIL halt_head: got %h/%0d expected 80/0", rd_pc, rd_order); end
        commit1(32'h90);
        n_tests++; if (order !== 64'd1 || count !== 3'd1) begin n_fail++; $display("FAIL halt_frozen: got order %0d count %0d expected 1/1", order, count); end
        pop1();
        n_tests++; if (rd_valid !== 1'b0 || halt !== 1'b1) begin n_fail++; $display("FAIL halt_read: got valid %0b halt %0b expected 0/1", rd_valid, halt); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) commit1(32'(4 * i));
        n_tests++; if (count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got count %0d ovf %0b expected 4/0", count, overflow); end
        commit1(32'h10);
        commit1(32'h14);
        n_tests++; if (count !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got count %0d ovf %0b expected 4/1", count, overflow); end
        n_tests++; if (rd_pc !== 32'h8 || rd_order !== 64'd2 || order !== 64'd6)
            begin n_fail++; $display("FAIL ovf_head: got pc %h rd_order %0d order %0d expected 8/2/6", rd_pc, rd_order, order); end
        pop1();
        n_tests++; if (rd_pc !== 32'hC || rd_order !== 64'd3 || count !== 3'd3)
            begin n_fail++; $display("FAIL ovf_pop: got pc %h rd_order %0d count %0d expected c/3/3", rd_pc, rd_order, count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) commit1(32'h100 + 32'(4 * i));
        clear_inputs();
        rd_en = 1'b1;
        set_lane(0, 32'h110, 32'h114, 1'b1, 5'd1, 32'h1);
        tick();
        clear_inputs();
        n_tests++; if (count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_count: got count %0d ovf %0b expected 4/0", count, overflow); end
        n_tests++; if (rd_pc !== 32'h104 || rd_order !== 64'd1) begin n_fail++; $display("FAIL b2b_head: got %h/%0d expected 104/1", rd_pc, rd_order); end
        rd_en = 1'b1;
        set_lane(0, 32'h114, 32'h118, 1'b1, 5'd1, 32'h1);
        set_lane(1, 32'h118, 32'h11C, 1'b1, 5'd1, 32'h1);
        tick();
        clear_inputs();
        n_tests++; if (count !== 3'd4 || overflow !== 1'b1 || order !== 64'd7)
            begin n_fail++; $display("FAIL b2b_dual_ovf: got count %0d ovf %0b order %0d expected 4/1/7", count, overflow, order); end
        n_tests++; if (rd_pc !== 32'h10C || rd_order !== 64'd3) begin n_fail++; $display("FAIL b2b_dual_head: got %h/%0d expected 10c/3", rd_pc, rd_order); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %0b expected 0", timeout); end
        tick();
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %0b expected 1", timeout); end
        commit1(32'h300);
        n_tests++; if (order !== 64'd0 || count !== 3'd0) begin n_fail++; $display("FAIL tmo_frozen: got order %0d count %0d expected 0/0", order, count); end

        do_reset();
        for (int i = 0; i < 4; i++) tick();
        commit1(32'h400);
        n_tests++; if (timeout !== 1'b0 || order !== 64'd1) begin n_fail++; $display("FAIL tmo_commit_clears: got tmo %0b order %0d expected 0/1", timeout, order); end
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_restart_early: got %0b expected 0", timeout); end
        tick();
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_set: got %0b expected 1", timeout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        commit1(32'h200);
        commit1(32'h204);
        clear_inputs();
        set_lane(0, 32'h208, 32'h208, 1'b0, 5'd0, 32'd0);
        tick();
        clear_inputs();
        n_tests++; if (halt !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL rmid_setup: got halt %0b count %0d expected 1/3", halt, count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (halt !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rmid_clear: got halt %0b count %0d expected 0/0", halt, count); end
        n_tests++; if (rd_valid !== 1'b0 || order !== 64'd0) begin n_fail++; $display("FAIL rmid_ring: got valid %0b order %0d expected 0/0", rd_valid, order); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        test_reset();
        test_single_lane();
        test_dual_lane();
        test_halt();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
